// File: rtl/fp_pkg.sv
// Shared floating-point helpers: format geometry, canonical NaN, and the divider state encoding.
package fp_pkg;

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} div_state_t;

  function automatic int float_width(int e, int m);
    return e + m + 1;
  endfunction

  function automatic int bias(int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // Negative quiet NaN; E4M3 has a single all-ones NaN encoding.
  function automatic logic [63:0] quiet_nan(int e, int m);
    logic [63:0] r;
    r = '0;
    if (e == 4 && m == 3) begin
      r[7:0] = 8'hFF;
    end else begin
      r[e+m] = 1'b1;
      for (int i = m - 1; i < e + m; i++) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/is_special_float.sv
// Classifies an unsigned float magnitude; subnormals report as zero (flush-to-zero library).
module is_special_float #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] magnitude,
  output logic                                     zero,
  output logic                                     inf,
  output logic                                     nan,
  output logic                                     snan
);
  localparam int M = MANTISSA_WIDTH;

  logic exp_zero, exp_ones, mant_zero;

  assign exp_zero  = (magnitude[EXPONENT_WIDTH+M-1:M] == '0);
  assign exp_ones  = &magnitude[EXPONENT_WIDTH+M-1:M];
  assign mant_zero = (magnitude[M-1:0] == '0);

  assign zero = exp_zero;
  assign inf  = exp_ones && mant_zero;
  assign nan  = exp_ones && !mant_zero;
  assign snan = nan && !magnitude[M-1];
endmodule

// File: rtl/result_rounder.sv
// Rounds {exponent, mantissa} using guard + sticky bits; mantissa carry ripples into the exponent.
module result_rounder #(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUNDING_BITS    = 2,
  parameter int ROUND_TO_NEAREST = 1
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] value,
  input  logic [ROUNDING_BITS-1:0]                 rounding_bits,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] rounded,
  output logic                                     overflow
);
  localparam int VW = EXPONENT_WIDTH + MANTISSA_WIDTH;

  logic guard, sticky, round_up;

  assign guard    = rounding_bits[ROUNDING_BITS-1];
  assign sticky   = |rounding_bits[ROUNDING_BITS-2:0];
  assign round_up = (ROUND_TO_NEAREST != 0) && guard && (sticky || value[0]);
  assign rounded  = value + VW'(round_up);
  assign overflow = &rounded[VW-1:MANTISSA_WIDTH];
endmodule

// File: rtl/floating_point_divider.sv
// Iterative flush-to-zero float divider: restoring division, one quotient bit per cycle,
// valid/ready on both sides. Specials resolve straight to DONE.
module floating_point_divider
  import fp_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int ROUND_TO_NEAREST = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out,
  output logic                                   underflow_flag,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag,
  output logic                                   divide_by_zero_flag
);
  localparam int E  = EXPONENT_WIDTH;
  localparam int M  = MANTISSA_WIDTH;
  localparam int W  = float_width(E, M);
  localparam int N  = M + 2;
  localparam int CW = $clog2(N + 1);
  localparam logic [63:0]          QNAN_WIDE = quiet_nan(E, M);
  localparam logic [W-1:0]         QNAN      = QNAN_WIDE[W-1:0];
  localparam logic signed [E+1:0]  BIAS_S    = (E+2)'(bias(E));
  localparam logic signed [E+1:0]  EXP_ONES  = (E+2)'((1 << E) - 1);
  localparam logic signed [E+1:0]  EXP_ZERO  = '0;
  localparam logic [CW-1:0]        N_CNT     = CW'(N);
  localparam logic [CW-1:0]        CNT_LAST  = CW'(1);

  div_state_t            state;
  logic [CW-1:0]         cnt;
  logic                  sign_q;
  logic signed [E+1:0]   exp_q;
  logic [M+1:0]          rem_q;
  logic [M:0]            div_q;
  logic [N-2:0]          quot_q;

  logic a_zero, a_inf, a_nan, a_snan;
  logic b_zero, b_inf, b_nan, b_snan;

  is_special_float #(.EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M)) u_spec_a (
    .magnitude(a[W-2:0]), .zero(a_zero), .inf(a_inf), .nan(a_nan), .snan(a_snan)
  );
  is_special_float #(.EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M)) u_spec_b (
    .magnitude(b[W-2:0]), .zero(b_zero), .inf(b_inf), .nan(b_nan), .snan(b_snan)
  );

  assign in_ready = (state == IDLE) && !rst;

  logic sign_in;
  assign sign_in = a[W-1] ^ b[W-1];

  logic         special, spec_inv, spec_dz;
  logic [W-1:0] spec_out;

  always_comb begin
    special  = 1'b1;
    spec_out = QNAN;
    spec_inv = 1'b0;
    spec_dz  = 1'b0;
    if (a_nan || b_nan) begin
      spec_inv = a_snan || b_snan;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_inv = 1'b1;
    end else if (b_zero && !a_inf) begin
      spec_out = {sign_in, {E{1'b1}}, {M{1'b0}}};
      spec_dz  = 1'b1;
    end else if (a_inf) begin
      spec_out = {sign_in, {E{1'b1}}, {M{1'b0}}};
    end else if (a_zero || b_inf) begin
      spec_out = {sign_in, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // Operand setup: pre-normalise so the first quotient bit is always the leading one.
  logic [M:0]          ma, mb;
  logic                pre_shift;
  logic signed [E+1:0] ea_s, eb_s, shift_s, exp_in;

  assign ma        = {1'b1, a[M-1:0]};
  assign mb        = {1'b1, b[M-1:0]};
  assign pre_shift = ma < mb;
  assign ea_s      = {2'b00, a[W-2:M]};
  assign eb_s      = {2'b00, b[W-2:M]};
  assign shift_s   = (E+2)'(pre_shift);
  assign exp_in    = ea_s - eb_s + BIAS_S - shift_s;

  logic [M+1:0] div_ext;
  logic         q_bit;
  logic [M:0]   rem_sel;

  assign div_ext = {1'b0, div_q};
  assign q_bit   = rem_q >= div_ext;
  assign rem_sel = q_bit ? (M+1)'(rem_q - div_ext) : rem_q[M:0];

  logic [E+M-1:0] rounded;
  logic           rnd_ovf;

  result_rounder #(
    .EXPONENT_WIDTH(E), .MANTISSA_WIDTH(M), .ROUNDING_BITS(2), .ROUND_TO_NEAREST(ROUND_TO_NEAREST)
  ) u_rounder (
    .value        ({exp_q[E-1:0], quot_q[N-2:1]}),
    .rounding_bits({quot_q[0], |rem_q}),
    .rounded      (rounded),
    .overflow     (rnd_ovf)
  );

  logic [W-1:0] norm_out;
  logic         norm_uf, norm_of;

  always_comb begin
    norm_out = {sign_q, rounded};
    norm_uf  = 1'b0;
    norm_of  = 1'b0;
    if (exp_q <= EXP_ZERO) begin
      norm_out = {sign_q, {(W-1){1'b0}}};
      norm_uf  = 1'b1;
    end else if (exp_q >= EXP_ONES || rnd_ovf) begin
      norm_out = {sign_q, {E{1'b1}}, {M{1'b0}}};
      norm_of  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      cnt                    <= '0;
      out_valid              <= 1'b0;
      out                    <= '0;
      underflow_flag         <= 1'b0;
      overflow_flag          <= 1'b0;
      invalid_operation_flag <= 1'b0;
      divide_by_zero_flag    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          if (special) begin
            out                    <= spec_out;
            underflow_flag         <= 1'b0;
            overflow_flag          <= 1'b0;
            invalid_operation_flag <= spec_inv;
            divide_by_zero_flag    <= spec_dz;
            out_valid              <= 1'b1;
            state                  <= DONE;
          end else begin
            cnt   <= N_CNT;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          cnt <= cnt - CNT_LAST;
          if (cnt == CNT_LAST) state <= ROUND;
        end
        ROUND: begin
          out                    <= norm_out;
          underflow_flag         <= norm_uf;
          overflow_flag          <= norm_of;
          invalid_operation_flag <= 1'b0;
          divide_by_zero_flag    <= 1'b0;
          out_valid              <= 1'b1;
          state                  <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: leading quotient bit falls off the top of quot_q after N shifts.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sign_q <= sign_in;
      exp_q  <= exp_in;
      div_q  <= mb;
      rem_q  <= pre_shift ? {ma, 1'b0} : {1'b0, ma};
    end else if (state == DIVIDE) begin
      rem_q  <= {rem_sel, 1'b0};
      quot_q <= {quot_q[N-3:0], q_bit};
    end
  end
endmodule

// File: tb/tb_floating_point_divider.sv
// FP32 bench: round-to-nearest and truncating dividers side by side against an integer-division model.
module tb_floating_point_divider;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [31:0] a, b;
  logic        in_ready, out_valid, uf, of, inv, dz;
  logic [31:0] out;
  logic        in_ready_z, out_valid_z, uf_z, of_z, inv_z, dz_z;
  logic [31:0] out_z;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  floating_point_divider #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(1)) dut_rn (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .underflow_flag(uf),
    .overflow_flag(of), .invalid_operation_flag(inv), .divide_by_zero_flag(dz)
  );
  floating_point_divider #(.EXPONENT_WIDTH(8), .MANTISSA_WIDTH(23), .ROUND_TO_NEAREST(0)) dut_rz (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_z), .a(a), .b(b),
    .out_valid(out_valid_z), .out_ready(out_ready), .out(out_z), .underflow_flag(uf_z),
    .overflow_flag(of_z), .invalid_operation_flag(inv_z), .divide_by_zero_flag(dz_z)
  );

  // Returns {underflow, overflow, invalid, div_by_zero, result}.
  function automatic logic [35:0] ref_div(input logic [31:0] x, input logic [31:0] y, input bit rtn);
    logic        s;
    logic [7:0]  ex, ey;
    logic [22:0] fx, fy, mant;
    logic        xz, xi, xn, xs, yz, yi, yn, ys, g, st;
    logic [63:0] num, den, q, r;
    logic [30:0] v;
    int          e;
    s  = x[31] ^ y[31];
    ex = x[30:23]; ey = y[30:23]; fx = x[22:0]; fy = y[22:0];
    xz = (ex == 0); xi = (ex == 255) && (fx == 0); xn = (ex == 255) && (fx != 0); xs = xn && !fx[22];
    yz = (ey == 0); yi = (ey == 255) && (fy == 0); yn = (ey == 255) && (fy != 0); ys = yn && !fy[22];
    if (xn || yn) return {2'b00, xs || ys, 1'b0, 32'hFFC00000};
    if ((xz && yz) || (xi && yi)) return {4'b0010, 32'hFFC00000};
    if (yz && !xi) return {4'b0001, s, 8'hFF, 23'd0};
    if (xi) return {4'b0000, s, 8'hFF, 23'd0};
    if (xz || yi) return {4'b0000, s, 31'd0};
    num = {40'd0, 1'b1, fx} << 26;
    den = {40'd0, 1'b1, fy};
    q = num / den;
    r = num % den;
    e = int'(ex) - int'(ey) + 127;
    if (q[26]) begin
      mant = q[25:3]; g = q[2]; st = (q[1:0] != 0) || (r != 0);
    end else begin
      e = e - 1; mant = q[24:2]; g = q[1]; st = q[0] || (r != 0);
    end
    if (e <= 0) return {4'b1000, s, 31'd0};
    if (e >= 255) return {4'b0100, s, 8'hFF, 23'd0};
    v = {e[7:0], mant};
    if (rtn && g && (st || mant[0])) v = v + 31'd1;
    if (v[30:23] == 8'hFF) return {4'b0100, s, 8'hFF, 23'd0};
    return {4'b0000, s, v};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] bits;
    logic [7:0]  e;
    int          sel;
    bits = $urandom;
    sel  = $urandom_range(0, 9);
    case (sel)
      0:       e = 8'd0;
      1:       e = 8'd255;
      2:       e = 8'($urandom_range(1, 4));
      3:       e = 8'($urandom_range(250, 254));
      default: e = 8'($urandom_range(1, 254));
    endcase
    if (sel == 1 && bits[31]) bits[22:0] = '0;
    return {bits[0], e, bits[22:0]};
  endfunction

  task automatic do_op(input logic [31:0] xa, input logic [31:0] xb,
                       output logic [31:0] rn, output logic [31:0] rz,
                       output logic [3:0] frn, output logic [3:0] frz, output int lat);
    a = xa; b = xb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rn = out; rz = out_z; frn = {uf, of, inv, dz}; frz = {uf_z, of_z, inv_z, dz_z};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out !== 32'h0 || {uf, of, inv, dz} !== 4'b0)
      $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h flags=%b, required 0 0 0 0000",
               in_ready, out_valid, out, {uf, of, inv, dz});
    else passed++;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset_release: in_ready=%b, required 1", in_ready);
    else passed++;
  endtask

  task automatic test_directed();
    logic [31:0] ta[8] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'hBF800000,
                           32'h00000000, 32'h7F800001, 32'h7F000000, 32'h00800000};
    logic [31:0] tb_[8] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                            32'h00000000, 32'h3F800000, 32'h3E800000, 32'h40000000};
    logic [31:0] ern[8] = '{32'h40400000, 32'h3EAAAAAB, 32'h7F800000, 32'hFF800000,
                            32'hFFC00000, 32'hFFC00000, 32'h7F800000, 32'h00000000};
    logic [31:0] erz[8] = '{32'h40400000, 32'h3EAAAAAA, 32'h7F800000, 32'hFF800000,
                            32'hFFC00000, 32'hFFC00000, 32'h7F800000, 32'h00000000};
    logic [3:0]  efl[8] = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b1000};
    int          elat[8] = '{27, 27, 1, 1, 1, 1, 27, 27};
    logic [31:0] rn, rz;
    logic [3:0]  frn, frz;
    int          lat;
    for (int i = 0; i < 8; i++) begin
      do_op(ta[i], tb_[i], rn, rz, frn, frz, lat);
      total++;
      if (rn !== ern[i]) $display("FAIL directed%0d_out_rn: got %h, required %h", i, rn, ern[i]);
      else passed++;
      total++;
      if (rz !== erz[i]) $display("FAIL directed%0d_out_rz: got %h, required %h", i, rz, erz[i]);
      else passed++;
      total++;
      if (frn !== efl[i] || frz !== efl[i])
        $display("FAIL directed%0d_flags: got rn=%b rz=%b, required %b", i, frn, frz, efl[i]);
      else passed++;
      total++;
      if (lat !== elat[i]) $display("FAIL directed%0d_latency: got %0d, required %0d", i, lat, elat[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] hold_out;
    logic [3:0]  hold_fl;
    int          lat;
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    hold_out = out; hold_fl = {uf, of, inv, dz};
    total++;
    if (hold_out !== 32'h40400000) $display("FAIL bp_result: got %h, required 40400000", hold_out);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (out !== hold_out || {uf, of, inv, dz} !== hold_fl || out_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: out=%h flags=%b out_valid=%b in_ready=%b, required %h %b 1 0",
                 i, out, {uf, of, inv, dz}, out_valid, in_ready, hold_out, hold_fl);
      else passed++;
    end
    a = 32'h3F800000; b = 32'h00000000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_to_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out !== 32'h7F800000 || dz !== 1'b1)
      $display("FAIL bp_held_accept: in_ready=%b out_valid=%b out=%h dz=%b, required 0 1 7f800000 1",
               in_ready, out_valid, out, dz);
    else passed++;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rn, rz;
    logic [3:0]  frn, frz;
    int          lat;
    bit          seen;
    a = 32'h40C00000; b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL midrst_in_ready_low: got %b, required 0", in_ready);
    else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL midrst_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid || out_valid_z) seen = 1'b1;
    end
    total++;
    if (seen) $display("FAIL midrst_no_result: out_valid seen=%b, required 0", seen);
    else passed++;
    do_op(32'h40C00000, 32'h40000000, rn, rz, frn, frz, lat);
    total++;
    if (rn !== 32'h40400000 || frn !== 4'b0 || lat !== 27)
      $display("FAIL midrst_next_op: out=%h flags=%b lat=%0d, required 40400000 0000 27", rn, frn, lat);
    else passed++;
  endtask

  task automatic test_random();
    logic [31:0] xa, xb, rn, rz;
    logic [3:0]  frn, frz;
    logic [35:0] mrn, mrz;
    int          lat, elat;
    for (int i = 0; i < 60; i++) begin
      xa = rand_fp(); xb = rand_fp();
      mrn = ref_div(xa, xb, 1'b1);
      mrz = ref_div(xa, xb, 1'b0);
      elat = (xa[30:23] == 0 || xa[30:23] == 255 || xb[30:23] == 0 || xb[30:23] == 255) ? 1 : 27;
      do_op(xa, xb, rn, rz, frn, frz, lat);
      total++;
      if (rn !== mrn[31:0] || frn !== mrn[35:32])
        $display("FAIL rand%0d_rn %h/%h: got %h flags %b, required %h flags %b",
                 i, xa, xb, rn, frn, mrn[31:0], mrn[35:32]);
      else passed++;
      total++;
      if (rz !== mrz[31:0] || frz !== mrz[35:32])
        $display("FAIL rand%0d_rz %h/%h: got %h flags %b, required %h flags %b",
                 i, xa, xb, rz, frz, mrz[31:0], mrz[35:32]);
      else passed++;
      total++;
      if (lat !== elat) $display("FAIL rand%0d_latency: got %0d, required %0d", i, lat, elat);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
    $fatal(1);
  end
endmodule

// File: doc/floating_point_divider.md
Name: floating_point_divider

Overview:
Iterative IEEE-754-style floating-point divider; the inverse operation of the team's combinational floating_point_multiplier, parametrized the same way. It computes a/b one quotient bit per cycle behind a valid/ready handshake on both sides. It sits beside the multiplier in the arithmetic library and reuses is_special_float and result_rounder.

Parameters:
EXPONENT_WIDTH, 8, exponent field width
MANTISSA_WIDTH, 23, stored mantissa width
ROUND_TO_NEAREST, 1, 0: round to zero (truncate), 1: round to nearest, ties to even (same semantics as the multiplier)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands valid
in_ready  out  1  divider can accept operands
a  in  E+M+1  dividend
b  in  E+M+1  divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out  out  E+M+1  quotient
underflow_flag  out  1  result flushed to zero
overflow_flag  out  1  result saturated to infinity
invalid_operation_flag  out  1  invalid operation
divide_by_zero_flag  out  1  finite nonzero divided by zero

Behaviour:
- One clock; reset is synchronous and active-high. Reset sets state IDLE, out_valid=0, out=0, all flags 0. in_ready=0 while rst is high. Reset mid-operation aborts the division; no out_valid is produced.
- States: IDLE, DIVIDE, ROUND, DONE. in_ready = (state==IDLE) && !rst.
- Accept happens when in_valid && in_ready; a and b are latched at that edge.
- Special-case resolution at accept goes IDLE->DONE, so out_valid is asserted 1 cycle after accept. Evaluate in this priority order:
  - Any NaN -> quiet NaN {1, all-ones exp, 1, zeros...; ones for E4M3}. invalid_operation_flag=1 only if either operand is a signaling NaN.
  - 0/0 or inf/inf -> quiet NaN, invalid_operation_flag=1.
  - finite nonzero / 0 -> signed infinity, divide_by_zero_flag=1.
  - inf/finite -> signed infinity, no flag.
  - 0/nonzero or finite/inf -> signed zero, no flag.
  - Subnormal operands are treated as zero (flush), consistent with the multiplier.
- Normal path:
  - sign = sa^sb.
  - ma={1,mant_a}, mb={1,mant_b}. If ma<mb, ma is shifted left by 1 and the exponent is decremented by 1.
  - Exponent is held as signed E+2 bits: ea - eb + bias - shift.
  - IDLE->DIVIDE runs a restoring division for N = MANTISSA_WIDTH+2 cycles, producing quotient bits leading, mantissa, guard (MSB first). The remainder is E-independent and M+2 bits wide.
  - DIVIDE->ROUND: sticky = (remainder != 0). result_rounder gets ROUNDING_BITS=2 and rounding_bits={guard, sticky}.
  - ROUND->DONE.
  - out_valid rises exactly N+2 cycles after accept (27 for FP32).
  - If exponent <= 0: signed zero, underflow_flag=1.
  - If exponent >= all-ones: signed infinity with zero mantissa, overflow_flag=1.
  - Rounder carry into an all-ones exponent also gives signed infinity with overflow_flag=1.
- DONE: out and all flags are registered and held stable while out_valid && !out_ready. DONE->IDLE on out_ready. in_ready stays low in DONE, so there is no accept in the same cycle as result handoff. Flags are valid only with out_valid.
- Counter wrap: the iteration counter is sized clog2(N+1), loaded at accept, and exits at 0. It does not run after exit.

Decomposition:
- Shared package fp_pkg:
  - divider state enum
  - float_width(E,M) function
  - quiet_nan(E,M) function, also usable by the multiplier
  - bias(E) function
- Reuse is_special_float (x2) and result_rounder (x1) unchanged.
- No new sub-module; the datapath and FSM stay in one module.

Test Plan (FP32 unless noted):
- 6.0/2.0: a=0x40C00000, b=0x40000000 -> out=0x40400000, flags 0, out_valid exactly 27 cycles after accept.
- 1.0/3.0: 0x3F800000 / 0x40400000 -> 0x3EAAAAAB with ROUND_TO_NEAREST=1; 0x3EAAAAAA with ROUND_TO_NEAREST=0.
- Divide by zero, out_valid 1 cycle after accept:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, divide_by_zero_flag=1.
  - 0xBF800000 / 0x00000000 -> 0xFF800000.
  - 0/0 -> 0xFFC00000, invalid=1.
  - 0x7F800001 / 0x3F800000 -> 0xFFC00000, invalid=1.
- Range limits:
  - 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow_flag=1.
  - 0x00800000 / 0x40000000 -> 0x00000000, underflow_flag=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out and flags stable, in_ready=0.
  - Pulse out_ready -> IDLE next cycle; a held in_valid is accepted the cycle after.
- Reset:
  - Assert rst in the DIVIDE cycle 10 -> no out_valid; in_ready=1 in the first cycle after rst deasserts.
  - A subsequent 6.0/2.0 gives the correct result.
